esp_flow_ctrl: RTL and testbench

Hardware RTS/CTS flow controller for the ESP8266 UART link on the Nexys 4 board. It sits between the MicroBlaze-side byte interface and the ESP8266 UART core's byte interface. It gates transmit bytes on the ESP8266's CTS and buffers received bytes in a FIFO. RTS is driven from FIFO occupancy with hysteresis, so firmware no longer bit-bangs RTS/CTS through GPIO.

---
 rtl/esp_flow_ctrl_pkg.sv | 16 +
 rtl/esp_flow_ctrl_if.sv | 39 +++
 rtl/esp_flow_ctrl_rx_fifo.sv | 64 ++++++
 rtl/esp_flow_ctrl.sv | 124 ++++++++++++
 tb/tb_esp_flow_ctrl.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/esp_flow_ctrl_pkg.sv
// Shared types and default parameters for the ESP8266 RTS/CTS flow controller.
package esp_flow_pkg;

  typedef enum logic [1:0] {IDLE, WAIT_CTS, SEND} tx_state_t;

  localparam int DEF_RX_DEPTH      = 16;
  localparam int DEF_RTS_OFF_LEVEL = 12;
  localparam int DEF_RTS_ON_LEVEL  = 4;
  localparam int DEF_TX_TIMEOUT    = 100_000_000;

  // The count has to represent a completely full FIFO, hence the extra bit.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/esp_flow_ctrl_if.sv
// Host-side, UART-side and status signals of the flow controller, grouped in one bundle.
interface esp_flow_ctrl_if #(
  parameter int RX_DEPTH = esp_flow_pkg::DEF_RX_DEPTH
);
  localparam int CW = esp_flow_pkg::cnt_width(RX_DEPTH);

  logic          cts_n;
  logic          rts_n;
  logic [7:0]    host_tx_data;
  logic          host_tx_valid;
  logic          host_tx_ready;
  logic [7:0]    uart_tx_data;
  logic          uart_tx_valid;
  logic          uart_tx_ready;
  logic [7:0]    uart_rx_data;
  logic          uart_rx_strobe;
  logic [7:0]    host_rx_data;
  logic          host_rx_valid;
  logic          host_rx_ready;
  logic [CW-1:0] rx_count;
  logic          overrun;
  logic          tx_timeout;
  logic          clr_status;

  modport slave (
    input  cts_n, host_tx_data, host_tx_valid, uart_tx_ready, uart_rx_data,
           uart_rx_strobe, host_rx_ready, clr_status,
    output rts_n, host_tx_ready, uart_tx_data, uart_tx_valid, host_rx_data,
           host_rx_valid, rx_count, overrun, tx_timeout
  );

  modport master (
    output cts_n, host_tx_data, host_tx_valid, uart_tx_ready, uart_rx_data,
           uart_rx_strobe, host_rx_ready, clr_status,
    input  rts_n, host_tx_ready, uart_tx_data, uart_tx_valid, host_rx_data,
           host_rx_valid, rx_count, overrun, tx_timeout
  );

endinterface

// File: rtl/esp_flow_ctrl_rx_fifo.sv
// Show-ahead receive FIFO with occupancy count; a push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module esp_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             not_empty_o,
  output logic             drop_o,
  output logic [CW-1:0]    count_o,
  output logic [CW-1:0]    count_next_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full, empty, wr_en, rd_en;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign rd_en = pop_i && !empty;
  assign wr_en = push_i && (!full || rd_en);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + CW'(wr_en) - CW'(rd_en);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o       = mem_q[rd_ptr_q];
  assign not_empty_o  = !empty;
  assign drop_o       = push_i && full && !rd_en;
  assign count_o      = count_q;
  assign count_next_o = count_d;

endmodule

// File: rtl/esp_flow_ctrl.sv
// RTS/CTS flow controller for the ESP8266 UART: CTS-gated TX holding stage,
// RX FIFO with RTS hysteresis, and sticky error status.
module esp_flow_ctrl
  import esp_flow_pkg::*;
#(
  parameter int RX_DEPTH      = DEF_RX_DEPTH,
  parameter int RTS_OFF_LEVEL = DEF_RTS_OFF_LEVEL,
  parameter int RTS_ON_LEVEL  = DEF_RTS_ON_LEVEL,
  parameter int TX_TIMEOUT    = DEF_TX_TIMEOUT
) (
  input  logic            sysclk,
  input  logic            sysreset,
  esp_flow_ctrl_if.slave  bus
);
  localparam int CW = cnt_width(RX_DEPTH);
  localparam int TW = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;

  tx_state_t     state_q, state_d;
  logic [7:0]    hold_q, hold_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          cts_meta_q, cts_sync_q, cts_ok;
  logic          rts_n_q, rts_n_d;
  logic          overrun_q, overrun_d;
  logic          tx_timeout_q, tx_timeout_d;
  logic          timeout_evt, fifo_drop;
  logic [CW-1:0] count, count_next;

  // Synchronizer flops reset to "not clear" so nothing is sent before CTS is seen.
  always_ff @(posedge sysclk) begin
    if (sysreset) begin
      cts_meta_q <= 1'b1;
      cts_sync_q <= 1'b1;
    end else begin
      cts_meta_q <= bus.cts_n;
      cts_sync_q <= cts_meta_q;
    end
  end
  assign cts_ok = ~cts_sync_q;

  always_comb begin
    state_d           = state_q;
    hold_d            = hold_q;
    timer_d           = timer_q;
    timeout_evt       = 1'b0;
    bus.host_tx_ready = 1'b0;
    bus.uart_tx_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.host_tx_ready = 1'b1;
        if (bus.host_tx_valid) begin
          hold_d  = bus.host_tx_data;
          timer_d = '0;
          state_d = WAIT_CTS;
        end
      end
      WAIT_CTS: begin
        if (cts_ok) begin
          state_d = SEND;
        end else if (timer_q == TW'(TX_TIMEOUT - 1)) begin
          timeout_evt = 1'b1;
          state_d     = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      SEND: begin
        bus.uart_tx_valid = 1'b1;
        if (bus.uart_tx_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Hysteresis looks at the next count so RTS moves right after the crossing edge.
  always_comb begin
    rts_n_d = rts_n_q;
    if (count_next >= CW'(RTS_OFF_LEVEL))     rts_n_d = 1'b1;
    else if (count_next <= CW'(RTS_ON_LEVEL)) rts_n_d = 1'b0;
    overrun_d    = fifo_drop   | (overrun_q    & ~bus.clr_status);
    tx_timeout_d = timeout_evt | (tx_timeout_q & ~bus.clr_status);
  end

  always_ff @(posedge sysclk) begin
    if (sysreset) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      timer_q      <= '0;
      rts_n_q      <= 1'b1;
      overrun_q    <= 1'b0;
      tx_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      timer_q      <= timer_d;
      rts_n_q      <= rts_n_d;
      overrun_q    <= overrun_d;
      tx_timeout_q <= tx_timeout_d;
    end
  end

  esp_rx_fifo #(
    .DEPTH (RX_DEPTH),
    .WIDTH (8),
    .CW    (CW)
  ) u_rx_fifo (
    .clk          (sysclk),
    .rst          (sysreset),
    .push_i       (bus.uart_rx_strobe),
    .push_data_i  (bus.uart_rx_data),
    .pop_i        (bus.host_rx_ready),
    .head_o       (bus.host_rx_data),
    .not_empty_o  (bus.host_rx_valid),
    .drop_o       (fifo_drop),
    .count_o      (count),
    .count_next_o (count_next)
  );

  assign bus.uart_tx_data = hold_q;
  assign bus.rts_n        = rts_n_q;
  assign bus.rx_count     = count;
  assign bus.overrun      = overrun_q;
  assign bus.tx_timeout   = tx_timeout_q;

endmodule

// File: tb/tb_esp_flow_ctrl.sv
// Directed testbench for esp_flow_ctrl: TX gating and timeout, RX FIFO,
// RTS hysteresis, overrun, status clear and mid-operation reset.
module tb_esp_flow_ctrl;
  logic sysclk = 1'b0;
  logic sysreset;
  int   nVectors = 0;
  int   nMiscompares = 0;

  esp_flow_ctrl_if #(.RX_DEPTH(16)) bus ();

  esp_flow_ctrl #(
    .RX_DEPTH      (16),
    .RTS_OFF_LEVEL (12),
    .RTS_ON_LEVEL  (4),
    .TX_TIMEOUT    (50)
  ) dut (
    .sysclk   (sysclk),
    .sysreset (sysreset),
    .bus      (bus)
  );

  always #5 sysclk = ~sysclk;

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic test_reset();
    sysreset = 1'b1;
    tick();
    tick();
    nVectors++; if (bus.host_tx_ready !== 1'b1) begin nMiscompares++; $display("[TB] FAIL reset_tx_ready: got %b expected 1", bus.host_tx_ready); end
    nVectors++; if (bus.uart_tx_valid !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_uart_valid: got %b expected 0", bus.uart_tx_valid); end
    nVectors++; if (bus.host_rx_valid !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_rx_valid: got %b expected 0", bus.host_rx_valid); end
    nVectors++; if (bus.rx_count !== 5'd0) begin nMiscompares++; $display("[TB] FAIL reset_count: got %0d expected 0", bus.rx_count); end
    nVectors++; if (bus.overrun !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_overrun: got %b expected 0", bus.overrun); end
    nVectors++; if (bus.tx_timeout !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_timeout: got %b expected 0", bus.tx_timeout); end
    nVectors++; if (bus.rts_n !== 1'b1) begin nMiscompares++; $display("[TB] FAIL reset_rts: got %b expected 1", bus.rts_n); end
    sysreset = 1'b0;
    tick();
    nVectors++; if (bus.rts_n !== 1'b0) begin nMiscompares++; $display("[TB] FAIL post_reset_rts: got %b expected 0", bus.rts_n); end
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    bus.cts_n         = 1'b0;
    bus.uart_tx_ready = 1'b1;
    tick();
    tick();
    bus.host_tx_data  = 8'hA5;
    bus.host_tx_valid = 1'b1;
    tick();
    bus.host_tx_data  = 8'h3C;
    nVectors++; if (bus.host_tx_ready !== 1'b0) begin nMiscompares++; $display("[TB] FAIL b2b_wait_ready: got %b expected 0", bus.host_tx_ready); end
    nVectors++; if (bus.uart_tx_valid !== 1'b0) begin nMiscompares++; $display("[TB] FAIL b2b_wait_valid: got %b expected 0", bus.uart_tx_valid); end
    tick();
    nVectors++; if (bus.uart_tx_valid !== 1'b1) begin nMiscompares++; $display("[TB] FAIL b2b_first_valid: got %b expected 1", bus.uart_tx_valid); end
    nVectors++; if (bus.uart_tx_data !== 8'hA5) begin nMiscompares++; $display("[TB] FAIL b2b_first_data: got %h expected a5", bus.uart_tx_data); end
    tick();
    nVectors++; if (bus.host_tx_ready !== 1'b1) begin nMiscompares++; $display("[TB] FAIL b2b_idle_ready: got %b expected 1", bus.host_tx_ready); end
    nVectors++; if (bus.uart_tx_valid !== 1'b0) begin nMiscompares++; $display("[TB] FAIL b2b_idle_valid: got %b expected 0", bus.uart_tx_valid); end
    tick();
    bus.host_tx_valid = 1'b0;
    tick();
    nVectors++; if (bus.uart_tx_valid !== 1'b1) begin nMiscompares++; $display("[TB] FAIL b2b_second_valid: got %b expected 1", bus.uart_tx_valid); end
    nVectors++; if (bus.uart_tx_data !== 8'h3C) begin nMiscompares++; $display("[TB] FAIL b2b_second_data: got %h expected 3c", bus.uart_tx_data); end
    tick();
    nVectors++; if (bus.tx_timeout !== 1'b0) begin nMiscompares++; $display("[TB] FAIL b2b_timeout: got %b expected 0", bus.tx_timeout); end
  endtask

  task automatic test_tx_timeout();
    int badValid = 0;
    bus.cts_n = 1'b1;
    tick();
    tick();
    tick();
    bus.host_tx_data  = 8'h11;
    bus.host_tx_valid = 1'b1;
    tick();
    bus.host_tx_valid = 1'b0;
    for (int i = 0; i < 49; i++) begin
      if (bus.uart_tx_valid !== 1'b0) badValid++;
      tick();
    end
    nVectors++; if (badValid !== 0) begin nMiscompares++; $display("[TB] FAIL to_valid_seen: got %0d cycles expected 0", badValid); end
    nVectors++; if (bus.host_tx_ready !== 1'b0) begin nMiscompares++; $display("[TB] FAIL to_still_waiting: got %b expected 0", bus.host_tx_ready); end
    nVectors++; if (bus.tx_timeout !== 1'b0) begin nMiscompares++; $display("[TB] FAIL to_early: got %b expected 0", bus.tx_timeout); end
    tick();
    nVectors++; if (bus.tx_timeout !== 1'b1) begin nMiscompares++; $display("[TB] FAIL to_flag: got %b expected 1", bus.tx_timeout); end
    nVectors++; if (bus.host_tx_ready !== 1'b1) begin nMiscompares++; $display("[TB] FAIL to_idle: got %b expected 1", bus.host_tx_ready); end
    nVectors++; if (bus.uart_tx_valid !== 1'b0) begin nMiscompares++; $display("[TB] FAIL to_valid: got %b expected 0", bus.uart_tx_valid); end
    bus.clr_status = 1'b1;
    tick();
    bus.clr_status = 1'b0;
    nVectors++; if (bus.tx_timeout !== 1'b0) begin nMiscompares++; $display("[TB] FAIL to_clear: got %b expected 0", bus.tx_timeout); end
  endtask

  task automatic test_cts_late();
    bit seen = 1'b0;
    bus.host_tx_data  = 8'h11;
    bus.host_tx_valid = 1'b1;
    tick();
    bus.host_tx_valid = 1'b0;
    for (int i = 0; i < 19; i++) tick();
    bus.cts_n = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (bus.uart_tx_valid === 1'b1) seen = 1'b1;
    end
    nVectors++; if (seen !== 1'b1) begin nMiscompares++; $display("[TB] FAIL late_valid: got %b expected 1 within 10 cycles", seen); end
    nVectors++; if (bus.uart_tx_data !== 8'h11) begin nMiscompares++; $display("[TB] FAIL late_data: got %h expected 11", bus.uart_tx_data); end
    tick();
    nVectors++; if (bus.tx_timeout !== 1'b0) begin nMiscompares++; $display("[TB] FAIL late_timeout: got %b expected 0", bus.tx_timeout); end
    nVectors++; if (bus.host_tx_ready !== 1'b1) begin nMiscompares++; $display("[TB] FAIL late_idle: got %b expected 1", bus.host_tx_ready); end
  endtask

  task automatic test_rx_hysteresis();
    for (int i = 0; i < 12; i++) begin
      bus.uart_rx_data   = 8'(i);
      bus.uart_rx_strobe = 1'b1;
      tick();
      if (i == 0) begin
        nVectors++; if (bus.host_rx_valid !== 1'b1) begin nMiscompares++; $display("[TB] FAIL rx_first_valid: got %b expected 1", bus.host_rx_valid); end
      end
      if (i == 10) begin
        nVectors++; if (bus.rts_n !== 1'b0) begin nMiscompares++; $display("[TB] FAIL rts_at_11: got %b expected 0", bus.rts_n); end
      end
    end
    bus.uart_rx_strobe = 1'b0;
    nVectors++; if (bus.rts_n !== 1'b1) begin nMiscompares++; $display("[TB] FAIL rts_at_12: got %b expected 1", bus.rts_n); end
    nVectors++; if (bus.rx_count !== 5'd12) begin nMiscompares++; $display("[TB] FAIL count_12: got %0d expected 12", bus.rx_count); end
    bus.host_rx_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      nVectors++; if (bus.host_rx_data !== 8'(i)) begin nMiscompares++; $display("[TB] FAIL pop_data_%0d: got %h expected %h", i, bus.host_rx_data, 8'(i)); end
      tick();
      if (i < 8) begin
        nVectors++; if (bus.rts_n !== ((i == 7) ? 1'b0 : 1'b1)) begin nMiscompares++; $display("[TB] FAIL pop_rts_%0d: got %b expected %b", i, bus.rts_n, (i == 7) ? 1'b0 : 1'b1); end
      end
    end
    bus.host_rx_ready = 1'b0;
    nVectors++; if (bus.rx_count !== 5'd0) begin nMiscompares++; $display("[TB] FAIL drain_count: got %0d expected 0", bus.rx_count); end
    nVectors++; if (bus.host_rx_valid !== 1'b0) begin nMiscompares++; $display("[TB] FAIL drain_valid: got %b expected 0", bus.host_rx_valid); end
  endtask

  task automatic test_overrun();
    logic [7:0] expData;
    for (int i = 0; i < 17; i++) begin
      bus.uart_rx_data   = 8'(8'h20 + i);
      bus.uart_rx_strobe = 1'b1;
      tick();
      if (i == 15) begin
        nVectors++; if (bus.overrun !== 1'b0) begin nMiscompares++; $display("[TB] FAIL ovr_at_full: got %b expected 0", bus.overrun); end
      end
    end
    bus.uart_rx_strobe = 1'b0;
    nVectors++; if (bus.rx_count !== 5'd16) begin nMiscompares++; $display("[TB] FAIL ovr_count: got %0d expected 16", bus.rx_count); end
    nVectors++; if (bus.overrun !== 1'b1) begin nMiscompares++; $display("[TB] FAIL ovr_flag: got %b expected 1", bus.overrun); end
    nVectors++; if (bus.host_rx_data !== 8'h20) begin nMiscompares++; $display("[TB] FAIL ovr_head: got %h expected 20", bus.host_rx_data); end
    bus.uart_rx_data   = 8'h55;
    bus.uart_rx_strobe = 1'b1;
    bus.host_rx_ready  = 1'b1;
    tick();
    bus.uart_rx_strobe = 1'b0;
    bus.host_rx_ready  = 1'b0;
    nVectors++; if (bus.rx_count !== 5'd16) begin nMiscompares++; $display("[TB] FAIL full_swap_count: got %0d expected 16", bus.rx_count); end
    nVectors++; if (bus.host_rx_data !== 8'h21) begin nMiscompares++; $display("[TB] FAIL full_swap_head: got %h expected 21", bus.host_rx_data); end
    bus.clr_status = 1'b1;
    tick();
    bus.clr_status = 1'b0;
    nVectors++; if (bus.overrun !== 1'b0) begin nMiscompares++; $display("[TB] FAIL ovr_clear: got %b expected 0", bus.overrun); end
    bus.uart_rx_data   = 8'h66;
    bus.uart_rx_strobe = 1'b1;
    bus.clr_status     = 1'b1;
    tick();
    bus.uart_rx_strobe = 1'b0;
    bus.clr_status     = 1'b0;
    nVectors++; if (bus.overrun !== 1'b1) begin nMiscompares++; $display("[TB] FAIL ovr_set_wins: got %b expected 1", bus.overrun); end
    nVectors++; if (bus.rx_count !== 5'd16) begin nMiscompares++; $display("[TB] FAIL ovr_drop_count: got %0d expected 16", bus.rx_count); end
    bus.host_rx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      expData = (i < 15) ? 8'(8'h21 + i) : 8'h55;
      nVectors++; if (bus.host_rx_data !== expData) begin nMiscompares++; $display("[TB] FAIL ovr_drain_%0d: got %h expected %h", i, bus.host_rx_data, expData); end
      tick();
    end
    bus.host_rx_ready = 1'b0;
    nVectors++; if (bus.rx_count !== 5'd0) begin nMiscompares++; $display("[TB] FAIL ovr_empty: got %0d expected 0", bus.rx_count); end
    bus.clr_status = 1'b1;
    tick();
    bus.clr_status = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      bus.uart_rx_data   = 8'(8'h70 + i);
      bus.uart_rx_strobe = 1'b1;
      tick();
    end
    bus.uart_rx_strobe = 1'b0;
    bus.uart_tx_ready  = 1'b0;
    bus.host_tx_data   = 8'h99;
    bus.host_tx_valid  = 1'b1;
    tick();
    bus.host_tx_valid  = 1'b0;
    tick();
    nVectors++; if (bus.uart_tx_valid !== 1'b1) begin nMiscompares++; $display("[TB] FAIL mid_in_send: got %b expected 1", bus.uart_tx_valid); end
    nVectors++; if (bus.rts_n !== 1'b0) begin nMiscompares++; $display("[TB] FAIL mid_rts_before: got %b expected 0", bus.rts_n); end
    sysreset = 1'b1;
    tick();
    nVectors++; if (bus.uart_tx_valid !== 1'b0) begin nMiscompares++; $display("[TB] FAIL mid_valid: got %b expected 0", bus.uart_tx_valid); end
    nVectors++; if (bus.rx_count !== 5'd0) begin nMiscompares++; $display("[TB] FAIL mid_count: got %0d expected 0", bus.rx_count); end
    nVectors++; if (bus.host_rx_valid !== 1'b0) begin nMiscompares++; $display("[TB] FAIL mid_rx_valid: got %b expected 0", bus.host_rx_valid); end
    nVectors++; if (bus.rts_n !== 1'b1) begin nMiscompares++; $display("[TB] FAIL mid_rts_reset: got %b expected 1", bus.rts_n); end
    sysreset = 1'b0;
    tick();
    nVectors++; if (bus.rts_n !== 1'b0) begin nMiscompares++; $display("[TB] FAIL mid_rts_release: got %b expected 0", bus.rts_n); end
    nVectors++; if (bus.host_tx_ready !== 1'b1) begin nMiscompares++; $display("[TB] FAIL mid_tx_ready: got %b expected 1", bus.host_tx_ready); end
    nVectors++; if (bus.uart_tx_valid !== 1'b0) begin nMiscompares++; $display("[TB] FAIL mid_valid_release: got %b expected 0", bus.uart_tx_valid); end
  endtask

  initial begin
    sysreset           = 1'b1;
    bus.cts_n          = 1'b0;
    bus.host_tx_data   = 8'h00;
    bus.host_tx_valid  = 1'b0;
    bus.uart_tx_ready  = 1'b0;
    bus.uart_rx_data   = 8'h00;
    bus.uart_rx_strobe = 1'b0;
    bus.host_rx_ready  = 1'b0;
    bus.clr_status     = 1'b0;
    test_reset();
    test_back_to_back();
    test_tx_timeout();
    test_cts_late();
    test_rx_hysteresis();
    test_overrun();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
